// File: rtl/aes_out_serializer.sv
// AES ciphertext output serializer: buffers 128-bit blocks and streams them out as 32-bit words.
// Optional word_out_last output is enabled by defining AES_OUT_SER_LAST_EN.
module aes_out_serializer #(
  parameter int BLOCK_W = 128,
  parameter int WORD_W  = 32,
  parameter int DEPTH   = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [BLOCK_W-1:0] blk_in,
  input  logic               blk_in_vld,
  output logic               blk_space,
  output logic [WORD_W-1:0]  word_out,
  output logic               word_out_vld,
`ifdef AES_OUT_SER_LAST_EN
  output logic               word_out_last,
`endif
  input  logic               word_out_rdy,
  output logic               ovf,
  input  logic               ovf_clr
);

  localparam int WORDS = BLOCK_W / WORD_W;
  localparam int PTR_W = $clog2(DEPTH);
  localparam int IDX_W = $clog2(WORDS);
  localparam int CNT_W = PTR_W + 1;

  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] SEND = 1'b1;

  logic [BLOCK_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [CNT_W-1:0]   count;
  logic [CNT_W-1:0]   count_next;
  logic [IDX_W-1:0]   w_idx;
  logic [IDX_W-1:0]   rev_idx;
  logic [0:0]         state;
  logic [0:0]         state_next;
  logic               handshake;
  logic               pop;
  logic               push;
  logic               drop;
  logic [BLOCK_W-1:0] cur_blk;

  assign handshake = (state == SEND) && word_out_rdy;
  assign pop       = handshake && (w_idx == LAST_IDX);
  // A full buffer still accepts a block when the head block leaves in the same cycle.
  assign push      = blk_in_vld && ((count < FULL_CNT) || pop);
  assign drop      = blk_in_vld && !push;

  // NOTE: every signal assigned in always_comb gets a default first so no latch is inferred.
  always_comb begin
    count_next = count;
    case ({push, pop})
      2'b10:   count_next = count + CNT_ONE;
      2'b01:   count_next = count - CNT_ONE;
      default: count_next = count;
    endcase

    state_next = state;
    case (state)
      IDLE:    if (push) state_next = SEND;
      SEND:    if (pop && (count_next == '0)) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      w_idx  <= '0;
      state  <= IDLE;
      ovf    <= 1'b0;
    end else begin
      count <= count_next;
      state <= state_next;
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
        w_idx  <= '0;
      end else if (handshake) begin
        w_idx <= w_idx + IDX_ONE;
      end
      // A drop in the same cycle as a clear leaves the flag set.
      if (drop)         ovf <= 1'b1;
      else if (ovf_clr) ovf <= 1'b0;
    end
  end

  // NOTE: the block storage has no reset; count=0 already marks every entry as empty,
  // and the output mux is gated by the FSM so stale contents never reach word_out.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= blk_in;
  end

  // Word 0 is the most significant slice of the block.
  assign cur_blk      = mem[rd_ptr];
  assign rev_idx      = LAST_IDX - w_idx;
  assign word_out_vld = (state == SEND);
  assign word_out     = word_out_vld ? cur_blk[rev_idx*WORD_W +: WORD_W] : '0;
  assign blk_space    = (count < FULL_CNT);

`ifdef AES_OUT_SER_LAST_EN
  assign word_out_last = word_out_vld && (w_idx == LAST_IDX);
`endif

endmodule

// File: tb/tb_aes_out_serializer.sv
// Directed self-checking bench for aes_out_serializer (DEPTH=2, 128->32 bit).
// Builds with or without AES_OUT_SER_LAST_EN.
module tb_aes_out_serializer;

  logic         clk = 1'b0;
  logic         reset;
  logic [127:0] blk_in;
  logic         blk_in_vld;
  logic         blk_space;
  logic [31:0]  word_out;
  logic         word_out_vld;
  logic         word_out_rdy;
  logic         ovf;
  logic         ovf_clr;
`ifdef AES_OUT_SER_LAST_EN
  logic         word_out_last;
`endif

  int total = 0;
  int bad   = 0;

  localparam logic [127:0] BLK_A = 128'h00112233_44556677_8899AABB_CCDDEEFF;
  localparam logic [127:0] BLK_B = 128'h01020304_05060708_090A0B0C_0D0E0F10;
  localparam logic [127:0] BLK_C = 128'hDEADBEEF_CAFEF00D_12345678_9ABCDEF0;
  localparam logic [127:0] BLK_D = 128'hFFFF0000_0000FFFF_A5A5A5A5_5A5A5A5A;

  aes_out_serializer dut (
    .clk          (clk),
    .reset        (reset),
    .blk_in       (blk_in),
    .blk_in_vld   (blk_in_vld),
    .blk_space    (blk_space),
    .word_out     (word_out),
    .word_out_vld (word_out_vld),
`ifdef AES_OUT_SER_LAST_EN
    .word_out_last(word_out_last),
`endif
    .word_out_rdy (word_out_rdy),
    .ovf          (ovf),
    .ovf_clr      (ovf_clr)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] wd(input logic [127:0] b, input int i);
    return b[127-32*i -: 32];
  endfunction

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic pulse(input logic [127:0] b);
    blk_in     = b;
    blk_in_vld = 1'b1;
    tick();
    blk_in_vld = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0; blk_in = '0; blk_in_vld = 1'b0; word_out_rdy = 1'b0; ovf_clr = 1'b0;
    #3;
    total += 4;
    if (word_out_vld !== 1'b0) begin bad++; $display("FAIL reset_vld got=%b exp=0", word_out_vld); end
    if (word_out !== 32'h0) begin bad++; $display("FAIL reset_word got=%h exp=0", word_out); end
    if (ovf !== 1'b0) begin bad++; $display("FAIL reset_ovf got=%b exp=0", ovf); end
    if (blk_space !== 1'b1) begin bad++; $display("FAIL reset_space got=%b exp=1", blk_space); end
    tick(); tick();
    reset = 1'b1;
    tick();
    total++;
    if (word_out_vld !== 1'b0) begin bad++; $display("FAIL post_reset_vld got=%b exp=0", word_out_vld); end
  endtask

  task automatic test_single();
    word_out_rdy = 1'b1;
    pulse(BLK_A);
    for (int i = 0; i < 4; i++) begin
      total += 2;
      if (word_out_vld !== 1'b1) begin bad++; $display("FAIL single_vld[%0d] got=%b exp=1", i, word_out_vld); end
      if (word_out !== wd(BLK_A, i)) begin bad++; $display("FAIL single_word[%0d] got=%h exp=%h", i, word_out, wd(BLK_A, i)); end
`ifdef AES_OUT_SER_LAST_EN
      total++;
      if (word_out_last !== (i == 3)) begin bad++; $display("FAIL single_last[%0d] got=%b exp=%b", i, word_out_last, (i == 3)); end
`endif
      tick();
    end
    total += 2;
    if (word_out_vld !== 1'b0) begin bad++; $display("FAIL single_end_vld got=%b exp=0", word_out_vld); end
    if (word_out !== 32'h0) begin bad++; $display("FAIL single_end_word got=%h exp=0", word_out); end
  endtask

  task automatic test_backpressure();
    logic [7:0] pat;
    int k;
    pat = 8'b0110_1001;
    k = 0;
    word_out_rdy = 1'b0;
    pulse(BLK_A);
    for (int c = 0; c < 32 && k < 4; c++) begin
      total += 2;
      if (word_out_vld !== 1'b1) begin bad++; $display("FAIL bp_vld[c%0d] got=%b exp=1", c, word_out_vld); end
      if (word_out !== wd(BLK_A, k)) begin bad++; $display("FAIL bp_word[c%0d] got=%h exp=%h", c, word_out, wd(BLK_A, k)); end
      word_out_rdy = pat[c % 8];
      tick();
      if (word_out_rdy) k++;
    end
    total += 2;
    if (k !== 4) begin bad++; $display("FAIL bp_count got=%0d exp=4", k); end
    if (word_out_vld !== 1'b0) begin bad++; $display("FAIL bp_end_vld got=%b exp=0", word_out_vld); end
  endtask

  task automatic test_overflow();
    word_out_rdy = 1'b0;
    pulse(BLK_A);
    total++;
    if (blk_space !== 1'b1) begin bad++; $display("FAIL ovf_space_a got=%b exp=1", blk_space); end
    pulse(BLK_B);
    total += 2;
    if (blk_space !== 1'b0) begin bad++; $display("FAIL ovf_space_b got=%b exp=0", blk_space); end
    if (ovf !== 1'b0) begin bad++; $display("FAIL ovf_before_c got=%b exp=0", ovf); end
    pulse(BLK_C);
    total += 2;
    if (ovf !== 1'b1) begin bad++; $display("FAIL ovf_set got=%b exp=1", ovf); end
    if (blk_space !== 1'b0) begin bad++; $display("FAIL ovf_space_c got=%b exp=0", blk_space); end
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    total++;
    if (ovf !== 1'b0) begin bad++; $display("FAIL ovf_clear got=%b exp=0", ovf); end
    // drop and clear together: the set must win
    ovf_clr = 1'b1;
    pulse(BLK_D);
    ovf_clr = 1'b0;
    total++;
    if (ovf !== 1'b1) begin bad++; $display("FAIL ovf_set_wins got=%b exp=1", ovf); end
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    word_out_rdy = 1'b1;
    for (int i = 0; i < 8; i++) begin
      logic [31:0] exp_w;
      exp_w = (i < 4) ? wd(BLK_A, i) : wd(BLK_B, i - 4);
      total += 2;
      if (word_out_vld !== 1'b1) begin bad++; $display("FAIL ovf_stream_vld[%0d] got=%b exp=1", i, word_out_vld); end
      if (word_out !== exp_w) begin bad++; $display("FAIL ovf_stream_word[%0d] got=%h exp=%h", i, word_out, exp_w); end
      tick();
    end
    total += 3;
    if (word_out_vld !== 1'b0) begin bad++; $display("FAIL ovf_end_vld got=%b exp=0", word_out_vld); end
    if (ovf !== 1'b0) begin bad++; $display("FAIL ovf_end_flag got=%b exp=0", ovf); end
    if (blk_space !== 1'b1) begin bad++; $display("FAIL ovf_end_space got=%b exp=1", blk_space); end
  endtask

  task automatic test_write_on_pop();
    logic [31:0] exp_w [12];
    for (int i = 0; i < 4; i++) begin
      exp_w[i]     = wd(BLK_A, i);
      exp_w[i + 4] = wd(BLK_B, i);
      exp_w[i + 8] = wd(BLK_C, i);
    end
    word_out_rdy = 1'b0;
    pulse(BLK_A);
    pulse(BLK_B);
    word_out_rdy = 1'b1;
    for (int i = 0; i < 12; i++) begin
      total += 2;
      if (word_out_vld !== 1'b1) begin bad++; $display("FAIL wop_vld[%0d] got=%b exp=1", i, word_out_vld); end
      if (word_out !== exp_w[i]) begin bad++; $display("FAIL wop_word[%0d] got=%h exp=%h", i, word_out, exp_w[i]); end
      blk_in     = BLK_C;
      blk_in_vld = (i == 3);
      tick();
      blk_in_vld = 1'b0;
    end
    total += 2;
    if (word_out_vld !== 1'b0) begin bad++; $display("FAIL wop_end_vld got=%b exp=0", word_out_vld); end
    if (ovf !== 1'b0) begin bad++; $display("FAIL wop_ovf got=%b exp=0", ovf); end
  endtask

  task automatic test_reset_mid();
    word_out_rdy = 1'b0;
    pulse(BLK_A);
    pulse(BLK_B);
    word_out_rdy = 1'b1;
    tick();
    tick();
    total++;
    if (word_out !== wd(BLK_A, 2)) begin bad++; $display("FAIL rmid_pre_word got=%h exp=%h", word_out, wd(BLK_A, 2)); end
    #2 reset = 1'b0;
    #1;
    total += 3;
    if (word_out_vld !== 1'b0) begin bad++; $display("FAIL rmid_vld got=%b exp=0", word_out_vld); end
    if (blk_space !== 1'b1) begin bad++; $display("FAIL rmid_space got=%b exp=1", blk_space); end
    if (word_out !== 32'h0) begin bad++; $display("FAIL rmid_word got=%h exp=0", word_out); end
    tick();
    reset = 1'b1;
    for (int c = 0; c < 6; c++) begin
      tick();
      total++;
      if (word_out_vld !== 1'b0) begin bad++; $display("FAIL rmid_idle_vld[%0d] got=%b exp=0", c, word_out_vld); end
    end
  endtask

  task automatic test_wrap();
    logic [127:0] blks [5];
    for (int k = 0; k < 5; k++)
      blks[k] = {32'hA000_0000 + 32'(k*16), 32'hA000_0001 + 32'(k*16),
                 32'hA000_0002 + 32'(k*16), 32'hA000_0003 + 32'(k*16)};
    word_out_rdy = 1'b1;
    for (int c = 0; c < 20; c++) begin
      blk_in     = blks[c / 4];
      blk_in_vld = (c % 4 == 0);
      tick();
      blk_in_vld = 1'b0;
      total += 2;
      if (word_out_vld !== 1'b1) begin bad++; $display("FAIL wrap_vld[%0d] got=%b exp=1", c, word_out_vld); end
      if (word_out !== wd(blks[c / 4], c % 4)) begin bad++; $display("FAIL wrap_word[%0d] got=%h exp=%h", c, word_out, wd(blks[c / 4], c % 4)); end
`ifdef AES_OUT_SER_LAST_EN
      total++;
      if (word_out_last !== (c % 4 == 3)) begin bad++; $display("FAIL wrap_last[%0d] got=%b exp=%b", c, word_out_last, (c % 4 == 3)); end
`endif
    end
    tick();
    total += 2;
    if (word_out_vld !== 1'b0) begin bad++; $display("FAIL wrap_end_vld got=%b exp=0", word_out_vld); end
    if (blk_space !== 1'b1) begin bad++; $display("FAIL wrap_end_space got=%b exp=1", blk_space); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_backpressure();
    test_overflow();
    test_write_on_pop();
    test_reset_mid();
    test_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/aes_out_serializer.md
Name: aes_out_serializer

Overview:
- Downstream stage of the AES flow controller.
- Captures each single-cycle 128-bit ciphertext pulse (data_out / data_out_vld), which has no backpressure, into a small block buffer.
- Streams each captured block out as 32-bit words over a valid/ready interface to the chip output bus.
- Flags blocks lost to overflow and reports free space upstream.

Parameters:
- BLOCK_W, 128, ciphertext block width in bits.
- WORD_W, 32, output word width in bits; BLOCK_W/WORD_W = 4 words per block.
- DEPTH, 2, number of block entries; power of two, ≥ 2.

Ports:
- clk  input  1  clock, rising edge
- reset  input  1  asynchronous, active-low reset
- blk_in  input  BLOCK_W  ciphertext block from the flow controller's data_out
- blk_in_vld  input  1  single-cycle strobe from the flow controller's data_out_vld
- blk_space  output  1  at least one free entry (count < DEPTH)
- word_out  output  WORD_W  current output word
- word_out_vld  output  1  word_out valid
- word_out_rdy  input  1  consumer ready
- ovf  output  1  sticky: a block was dropped
- ovf_clr  input  1  synchronous clear of ovf

Behaviour:
- Reset (asynchronous, active-low): all state clears immediately and independently of clk.
  - Pointers, count and word index clear to 0; FSM goes to IDLE.
  - Outputs: word_out_vld=0, word_out=0, ovf=0, blk_space=1.
  - Reset asserted mid-stream discards all buffered blocks and any partially sent block; no word is emitted after reset releases until a new blk_in_vld arrives.
- Storage:
  - DEPTH x BLOCK_W registers.
  - wr_ptr and rd_ptr are log2(DEPTH) bits and wrap modulo DEPTH.
  - count is log2(DEPTH)+1 bits.
- Write: on a rising edge with blk_in_vld=1, the block is written at wr_ptr and wr_ptr increments if either:
  - count < DEPTH, or
  - a pop occurs in the same cycle.
- Overflow: if blk_in_vld=1, count == DEPTH and no pop occurs that cycle:
  - the block is dropped, and ovf is set to 1;
  - ovf holds until ovf_clr=1 or reset;
  - if ovf_clr=1 and a drop occur in the same cycle, set wins (ovf=1).
- Word order: word index w_idx runs 0..3.
  - w_idx 0 = blk[127:96], 1 = blk[95:64], 2 = blk[63:32], 3 = blk[31:0].
  - This is the same word ordering as the flow controller's store registers.
- FSM states:
  - IDLE: word_out_vld=0, word_out=0. Go to SEND when count becomes nonzero.
  - SEND: word_out_vld=1; word_out = entry[rd_ptr] word w_idx, driven from registered state only.
    - On word_out_vld && word_out_rdy, w_idx increments.
    - When the handshake occurs with w_idx==3 (pop): w_idx→0, rd_ptr increments, count decrements. Then stay in SEND if the post-update count > 0, else go to IDLE.
- Latency:
  - A block written at edge N gives word_out_vld=1 in the cycle after edge N, with word 0 presented, when the FSM was IDLE.
  - With word_out_rdy held high, the four words complete on consecutive cycles.
  - Back-to-back buffered blocks stream with no bubble.
- Stall: while word_out_vld=1 and word_out_rdy=0, word_out and word_out_vld hold stable.
- Simultaneous write and pop in the same cycle: count is unchanged; both pointers advance.
- blk_space is combinational from count and does not reflect same-cycle pops.
- word_out_rdy is ignored while word_out_vld=0.

Optional Feature:
- Macro: AES_OUT_SER_LAST_EN.
- Defined: adds output port word_out_last (1 bit).
  - word_out_last = word_out_vld && (w_idx==3).
  - Reset value 0.
- Undefined: the port is absent; behaviour is otherwise identical.

Test Plan:
- Single block, rdy always 1: blk_in=0x00112233_44556677_8899AABB_CCDDEEFF pulsed at edge N → words 0x00112233, 0x44556677, 0x8899AABB, 0xCCDDEEFF on cycles N+1..N+4, then vld=0. With the macro defined, last=1 only on 0xCCDDEEFF.
- Backpressure: same block with rdy toggling 1,0,0,1,… → each word held stable across the rdy=0 cycles, no word skipped or duplicated, order preserved.
- Fill and overflow, DEPTH=2, rdy=0: three pulses A, B, C → blk_space=0 after B, C dropped, ovf=1. Releasing rdy then yields the 8 words of A followed by B. ovf_clr=1 → ovf=0 next cycle.
- Write on pop, full buffer: a pulse coinciding with the handshake of A's word 3 → accepted, ovf stays 0, and A, B, new block emerge in order.
- Reset mid-stream: assert reset after word 1 of block A with B buffered → word_out_vld=0 and blk_space=1 immediately. After release with no stimulus, no output appears.
- Pointer wrap: 5 blocks streamed back-to-back with rdy=1 → 20 words, correct order, no bubble between blocks, count returns to 0.
